apb_mem_slave: RTL



---
 rtl/apb_mem_slave_pkg.sv | 16 +
 rtl/apb_mem_array.sv | 35 +++
 rtl/apb_mem_slave.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/apb_mem_slave_pkg.sv
// Shared types and sizing helpers for the APB4 memory slave.
package apb_mem_slave_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Byte-offset bits inside one data word.
    function automatic int unsigned addr_lsb(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    // Wait-state counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned wait_states);
        return (wait_states == 0) ? 1 : $clog2(wait_states + 1);
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_WIDTH RAM: one byte-enabled write port, asynchronous read, cleared on reset.
module apb_mem_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned IDX_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [IDX_W-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [IDX_W-1:0]        raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
                if (be[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_mem_slave.sv
// Parametrised APB4 memory slave with wait states, byte strobes and error response.
// Optional PPROT privilege check on writes: define APB_MEM_SLAVE_PPROT_EN.
module apb_mem_slave
    import apb_mem_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
`ifdef APB_MEM_SLAVE_PPROT_EN
    input  logic [2:0]              PPROT,
`endif
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int unsigned NB        = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB  = addr_lsb(DATA_WIDTH);
    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W     = cnt_width(WAIT_STATES);
    localparam int unsigned MEM_BYTES = DEPTH * NB;
    localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((1 << ADDR_LSB) - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    latch;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NB-1:0]           strb_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   prdata_q;

    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic                    cur_write;
    logic                    cur_priv;
    logic                    cur_err;
    logic                    commit;
    logic [DATA_WIDTH-1:0]   rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (PSEL) begin
                    latch = 1'b1;
                    if (WAIT_STATES > 0) begin
                        cnt_d   = CNT_W'(WAIT_STATES);
                        state_d = WAIT;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (!(PSEL && PENABLE)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RESP;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states RESP is entered straight from the setup cycle, before the latch.
    assign cur_addr  = (state_q == IDLE) ? PADDR  : addr_q;
    assign cur_write = (state_q == IDLE) ? PWRITE : write_q;

`ifdef APB_MEM_SLAVE_PPROT_EN
    logic [2:0] prot_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            prot_q <= '0;
        end else if (latch) begin
            prot_q <= PPROT;
        end
    end

    assign cur_priv = (state_q == IDLE) ? PPROT[0] : prot_q[0];
`else
    assign cur_priv = 1'b1;
`endif

    assign cur_err = ((cur_addr & LSB_MASK) != '0)
                   || (64'(cur_addr) >= 64'(MEM_BYTES))
                   || (cur_write && !cur_priv);

    assign commit = (state_q == RESP) && PSEL && PENABLE && write_q && !err_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            err_q    <= 1'b0;
            prdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                addr_q  <= PADDR;
                write_q <= PWRITE;
                wdata_q <= PWDATA;
                strb_q  <= PSTRB;
            end
            if (state_d == RESP) begin
                err_q <= cur_err;
                if (cur_err) begin
                    prdata_q <= '0;
                end else if (!cur_write) begin
                    prdata_q <= rdata;
                end
            end
        end
    end

    apb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk   (PCLK),
        .rst   (PRESET),
        .we    (commit),
        .be    (strb_q),
        .waddr (addr_q[ADDR_LSB +: IDX_W]),
        .wdata (wdata_q),
        .raddr (cur_addr[ADDR_LSB +: IDX_W]),
        .rdata (rdata)
    );

    assign PRDATA  = prdata_q;
    assign PREADY  = (state_q == RESP);
    assign PSLVERR = (state_q == RESP) && err_q;

endmodule
